// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops words from the async FIFO read port and packs RATIO
// consecutive words into one wide beat on a valid/ready stream. A partially
// filled beat is flushed after TIMEOUT idle cycles, with m_keep marking
// which lanes hold data. TIMEOUT=0 disables flushing.
module fifo_rd_packer #(
  parameter int DSIZE   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic [DSIZE-1:0]       rdata,
  input  logic                   rempty,
  output logic                   rout,
  output logic [DSIZE*RATIO-1:0] m_data,
  output logic [RATIO-1:0]       m_keep,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int             CW       = $clog2(RATIO + 1);
  localparam logic [CW-1:0]  FULL     = CW'(RATIO);
  localparam logic [TW-1:0]  IDLE_MAX = TW'(TIMEOUT);
  localparam bit             FLUSH_EN = (TIMEOUT != 0);

  logic [DSIZE*RATIO-1:0] acc;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_base;
  logic [CW-1:0]          cnt_next;
  logic [TW-1:0]          idle;
  logic                   flush_req;
  logic                   xfer;
  logic [DSIZE*RATIO-1:0] beat_data;
  logic [RATIO-1:0]       beat_keep;

  // Handshake decisions: a full or flush-pending beat blocks further pops
  // until it moves to the output register; a pop in the transfer cycle
  // starts the next beat in lane 0.
  always_comb begin
    flush_req = FLUSH_EN && (cnt != '0) && (cnt < FULL) && (idle == IDLE_MAX);
    xfer      = ((cnt == FULL) || flush_req) && (!m_valid || m_ready);
    rout      = rrst_n && !rempty && (xfer || ((cnt < FULL) && !flush_req));
    cnt_base  = xfer ? '0 : cnt;
    cnt_next  = rout ? (cnt_base + CW'(1)) : cnt_base;
  end

  // Assemble the outgoing beat: lanes at or above cnt are zeroed, keep is
  // the thermometer mask of filled lanes.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CW'(i) < cnt) begin
        beat_data[i*DSIZE +: DSIZE] = acc[i*DSIZE +: DSIZE];
        beat_keep[i]                = 1'b1;
      end
    end
  end

  // Output register: loaded on transfer, held stable while stalled.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data  <= beat_data;
      m_keep  <= beat_keep;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Accumulator: each popped word lands in the next free lane, ascending.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      if (rout) begin
        for (int i = 0; i < RATIO; i++) begin
          if (cnt_base == CW'(i)) begin
            acc[i*DSIZE +: DSIZE] <= rdata;
          end
        end
      end
      cnt <= cnt_next;
    end
  end

  // Idle counter: counts cycles without a pop while a partial beat waits,
  // saturating at TIMEOUT so the flush request stays asserted.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      idle <= '0;
    end else if (rout || xfer || (cnt_next == '0)) begin
      idle <= '0;
    end else if (idle != IDLE_MAX) begin
      idle <= idle + TW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed testbench for fifo_rd_packer. A queue models the async FIFO
// read side; u_dut uses TIMEOUT=16, u_dut_nt uses TIMEOUT=0.
module tb_fifo_rd_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rout;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;

  logic [7:0]  rdata_b;
  logic        rempty_b;
  logic        rout_b;
  logic [31:0] m_data_b;
  logic [3:0]  m_keep_b;
  logic        m_valid_b;
  logic        m_ready_b;

  int vectors = 0;
  int misc    = 0;
  int cyc     = 0;

  logic [7:0]  fq[$];
  int          pop_cyc[$];
  int          valid_cyc[$];
  logic [31:0] beat_d[$];
  logic [3:0]  beat_k[$];

  fifo_rd_packer #(.DSIZE(8), .RATIO(4), .TIMEOUT(16), .TW(8)) u_dut (
    .rclk(clk), .rrst_n(rst_n), .rdata(rdata), .rempty(rempty), .rout(rout),
    .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready)
  );

  fifo_rd_packer #(.DSIZE(8), .RATIO(4), .TIMEOUT(0), .TW(8)) u_dut_nt (
    .rclk(clk), .rrst_n(rst_n), .rdata(rdata_b), .rempty(rempty_b), .rout(rout_b),
    .m_data(m_data_b), .m_keep(m_keep_b), .m_valid(m_valid_b), .m_ready(m_ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_logs();
    pop_cyc.delete();
    valid_cyc.delete();
    beat_d.delete();
    beat_k.delete();
  endtask

  // One clock cycle: present the FIFO head, sample just before the edge,
  // retire the popped word after the edge, return on the falling edge.
  task automatic step();
    logic r;
    rempty = (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
    r = rout;
    if (r) pop_cyc.push_back(cyc);
    if (m_valid) valid_cyc.push_back(cyc);
    if (m_valid && m_ready) begin
      beat_d.push_back(m_data);
      beat_k.push_back(m_keep);
    end
    @(posedge clk);
    if (r) void'(fq.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    rempty = 1'b0;
    rdata  = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    vectors++; if (rout !== 1'b0) begin misc++; $display("FAIL reset_rout: got %b expected 0", rout); end
    vectors++; if (m_valid !== 1'b0) begin misc++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    vectors++; if (m_data !== 32'h0) begin misc++; $display("FAIL reset_data: got %h expected 00000000", m_data); end
    vectors++; if (m_keep !== 4'h0) begin misc++; $display("FAIL reset_keep: got %b expected 0000", m_keep); end
    rst_n = 1'b1;
    clear_logs();
    repeat (5) step();
    vectors++; if (pop_cyc.size() != 0) begin misc++; $display("FAIL reset_idle_pops: got %0d expected 0", pop_cyc.size()); end
    vectors++; if (valid_cyc.size() != 0) begin misc++; $display("FAIL reset_idle_valid: got %0d expected 0", valid_cyc.size()); end
  endtask

  task automatic test_full_pack();
    clear_logs();
    m_ready = 1'b1;
    fq = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (8) step();
    vectors++; if (pop_cyc.size() != 4) begin misc++; $display("FAIL full_pops: got %0d expected 4", pop_cyc.size()); end
    else begin
      vectors++; if (pop_cyc[3] - pop_cyc[0] != 3) begin misc++; $display("FAIL full_pop_span: got %0d expected 3", pop_cyc[3] - pop_cyc[0]); end
    end
    vectors++; if (beat_d.size() != 1 || valid_cyc.size() != 1) begin
      misc++; $display("FAIL full_beats: got %0d beats %0d valid cycles expected 1 1", beat_d.size(), valid_cyc.size());
    end else begin
      vectors++; if (beat_d[0] !== 32'h44332211) begin misc++; $display("FAIL full_data: got %h expected 44332211", beat_d[0]); end
      vectors++; if (beat_k[0] !== 4'b1111) begin misc++; $display("FAIL full_keep: got %b expected 1111", beat_k[0]); end
      if (pop_cyc.size() == 4) begin
        vectors++; if (valid_cyc[0] - pop_cyc[3] != 2) begin misc++; $display("FAIL full_latency: got %0d expected 2", valid_cyc[0] - pop_cyc[3]); end
      end
    end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h04030201;
    exp_d[1] = 32'h08070605;
    exp_d[2] = 32'h0C0B0A09;
    clear_logs();
    m_ready = 1'b1;
    for (int i = 1; i <= 12; i++) fq.push_back(8'(i));
    repeat (16) step();
    vectors++; if (pop_cyc.size() != 12) begin misc++; $display("FAIL stream_pops: got %0d expected 12", pop_cyc.size()); end
    else begin
      vectors++; if (pop_cyc[11] - pop_cyc[0] != 11) begin misc++; $display("FAIL stream_bubbles: got span %0d expected 11", pop_cyc[11] - pop_cyc[0]); end
    end
    vectors++; if (beat_d.size() != 3 || valid_cyc.size() != 3) begin
      misc++; $display("FAIL stream_beats: got %0d beats %0d valid cycles expected 3 3", beat_d.size(), valid_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++; if (beat_d[i] !== exp_d[i]) begin misc++; $display("FAIL stream_data%0d: got %h expected %h", i, beat_d[i], exp_d[i]); end
        vectors++; if (beat_k[i] !== 4'b1111) begin misc++; $display("FAIL stream_keep%0d: got %b expected 1111", i, beat_k[i]); end
      end
      vectors++; if (valid_cyc[1] - valid_cyc[0] != 4 || valid_cyc[2] - valid_cyc[1] != 4) begin
        misc++; $display("FAIL stream_spacing: got %0d %0d expected 4 4", valid_cyc[1] - valid_cyc[0], valid_cyc[2] - valid_cyc[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bit          seen;
    int          changes;
    seen    = 1'b0;
    changes = 0;
    held    = '0;
    clear_logs();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fq.push_back(8'h80 + 8'(i));
    repeat (20) begin
      step();
      if (m_valid) begin
        if (!seen) begin held = m_data; seen = 1'b1; end
        else if (m_data !== held) changes++;
      end
    end
    vectors++; if (pop_cyc.size() != 8) begin misc++; $display("FAIL bp_pops: got %0d expected 8", pop_cyc.size()); end
    vectors++; if (!seen || held !== 32'h84838281) begin misc++; $display("FAIL bp_held_data: got %h expected 84838281", held); end
    vectors++; if (changes != 0) begin misc++; $display("FAIL bp_stable: got %0d changes expected 0", changes); end
    // Offer another word without a clock edge: a blocked full beat must not pop.
    rempty = 1'b0;
    rdata  = 8'hEE;
    #1;
    vectors++; if (rout !== 1'b0) begin misc++; $display("FAIL bp_rout_blocked: got %b expected 0", rout); end
    rempty = 1'b1;
    m_ready = 1'b1;
    repeat (6) step();
    vectors++; if (beat_d.size() != 2) begin misc++; $display("FAIL bp_beats: got %0d expected 2", beat_d.size()); end
    else begin
      vectors++; if (beat_d[0] !== 32'h84838281) begin misc++; $display("FAIL bp_beat0: got %h expected 84838281", beat_d[0]); end
      vectors++; if (beat_d[1] !== 32'h88878685) begin misc++; $display("FAIL bp_beat1: got %h expected 88878685", beat_d[1]); end
      vectors++; if (beat_k[1] !== 4'b1111) begin misc++; $display("FAIL bp_keep1: got %b expected 1111", beat_k[1]); end
    end
  endtask

  task automatic test_timeout_flush();
    clear_logs();
    m_ready = 1'b1;
    fq.push_back(8'hA5);
    repeat (22) step();
    vectors++; if (pop_cyc.size() != 1) begin misc++; $display("FAIL flush_pops: got %0d expected 1", pop_cyc.size()); end
    vectors++; if (beat_d.size() != 1 || valid_cyc.size() != 1) begin
      misc++; $display("FAIL flush_beats: got %0d beats %0d valid cycles expected 1 1", beat_d.size(), valid_cyc.size());
    end else begin
      vectors++; if (beat_d[0] !== 32'h000000A5) begin misc++; $display("FAIL flush_data: got %h expected 000000a5", beat_d[0]); end
      vectors++; if (beat_k[0] !== 4'b0001) begin misc++; $display("FAIL flush_keep: got %b expected 0001", beat_k[0]); end
      if (pop_cyc.size() == 1) begin
        vectors++; if (valid_cyc[0] - pop_cyc[0] != 18) begin misc++; $display("FAIL flush_latency: got %0d expected 18", valid_cyc[0] - pop_cyc[0]); end
      end
    end
  endtask

  task automatic test_timeout_race();
    clear_logs();
    m_ready = 1'b1;
    fq = '{8'h5A, 8'h6B};
    repeat (2) step();
    repeat (15) step();
    vectors++; if (beat_d.size() != 0 || valid_cyc.size() != 0) begin misc++; $display("FAIL race_early_beat: got %0d expected 0", valid_cyc.size()); end
    fq.push_back(8'h7C);
    step();
    fq.push_back(8'h8D);
    step();
    repeat (6) step();
    vectors++; if (pop_cyc.size() != 4) begin misc++; $display("FAIL race_pops: got %0d expected 4", pop_cyc.size()); end
    else begin
      vectors++; if (pop_cyc[2] - pop_cyc[0] != 17) begin misc++; $display("FAIL race_third_pop: got %0d expected 17", pop_cyc[2] - pop_cyc[0]); end
    end
    vectors++; if (beat_d.size() != 1) begin misc++; $display("FAIL race_beats: got %0d expected 1", beat_d.size()); end
    else begin
      vectors++; if (beat_d[0] !== 32'h8D7C6B5A) begin misc++; $display("FAIL race_data: got %h expected 8d7c6b5a", beat_d[0]); end
      vectors++; if (beat_k[0] !== 4'b1111) begin misc++; $display("FAIL race_keep: got %b expected 1111", beat_k[0]); end
    end
  endtask

  task automatic test_timeout_disabled();
    int nvalid;
    nvalid    = 0;
    m_ready_b = 1'b1;
    rempty_b  = 1'b0;
    rdata_b   = 8'hA5;
    #1;
    vectors++; if (rout_b !== 1'b1) begin misc++; $display("FAIL nt_pop: got %b expected 1", rout_b); end
    @(posedge clk);
    @(negedge clk);
    rempty_b = 1'b1;
    repeat (40) begin
      #1;
      if (m_valid_b) nvalid++;
      @(negedge clk);
    end
    vectors++; if (nvalid != 0) begin misc++; $display("FAIL nt_no_flush: got %0d valid cycles expected 0", nvalid); end
  endtask

  initial begin
    rst_n     = 1'b0;
    rempty    = 1'b1;
    rdata     = 8'h00;
    m_ready   = 1'b1;
    rempty_b  = 1'b1;
    rdata_b   = 8'h00;
    m_ready_b = 1'b1;
    test_reset();
    test_full_pack();
    test_streaming();
    test_backpressure();
    test_timeout_flush();
    test_timeout_race();
    test_timeout_disabled();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
